// File: rtl/ysyx_25030077_pc_pkg.sv
// Shared next-PC type codes, FSM states and immediate extraction for the pc_gen slice.
package ysyx_25030077_pc_pkg;

    localparam logic [3:0] PC_TYPE_SNPC    = 4'd0;
    localparam logic [3:0] PC_TYPE_JAL     = 4'd1;
    localparam logic [3:0] PC_TYPE_JALR    = 4'd2;
    localparam logic [3:0] PC_TYPE_UNKNOWN = 4'd3;
    localparam logic [3:0] PC_TYPE_HALT    = 4'd4;
    localparam logic [3:0] PC_TYPE_BNE     = 4'd5;
    localparam logic [3:0] PC_TYPE_BEQ     = 4'd6;
    localparam logic [3:0] PC_TYPE_BGE     = 4'd7;
    localparam logic [3:0] PC_TYPE_BGEU    = 4'd8;
    localparam logic [3:0] PC_TYPE_BLT     = 4'd9;
    localparam logic [3:0] PC_TYPE_BLTU    = 4'd10;
    localparam logic [3:0] PC_TYPE_TRAP    = 4'd11;
    localparam logic [3:0] PC_TYPE_MRET    = 4'd12;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } pc_state_e;

    function automatic logic signed [31:0] imm_b(input logic [31:0] instr);
        return 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] instr);
        return 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    endfunction

    function automatic logic signed [31:0] imm_i(input logic [31:0] instr);
        return 32'($signed(instr[31:20]));
    endfunction

endpackage

// File: rtl/ysyx_25030077_pc_target.sv
// Combinational branch compare and next-PC target mux; no state.
module ysyx_25030077_pc_target
    import ysyx_25030077_pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TYPE_W = 4
) (
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [31:0]       instr,
    input  logic [TYPE_W-1:0] next_type,
    output logic [XLEN-1:0]   target,
    output logic              ctrl_xfer
);

    logic [XLEN-1:0] snpc;
    logic [XLEN-1:0] imm_b_x;
    logic [XLEN-1:0] imm_j_x;
    logic [XLEN-1:0] imm_i_x;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            is_branch;
    logic            taken;
    logic            unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        snpc    = pc + XLEN'(4);
        imm_b_x = XLEN'(imm_b(instr));
        imm_j_x = XLEN'(imm_j(instr));
        imm_i_x = XLEN'(imm_i(instr));
        eq      = (rs1 == rs2);
        lt_s    = ($signed(rs1) < $signed(rs2));
        lt_u    = (rs1 < rs2);

        is_branch = 1'b1;
        taken     = 1'b0;
        case (next_type)
            TYPE_W'(PC_TYPE_BEQ):  taken = eq;
            TYPE_W'(PC_TYPE_BNE):  taken = !eq;
            TYPE_W'(PC_TYPE_BGE):  taken = !lt_s;
            TYPE_W'(PC_TYPE_BGEU): taken = !lt_u;
            TYPE_W'(PC_TYPE_BLT):  taken = lt_s;
            TYPE_W'(PC_TYPE_BLTU): taken = lt_u;
            default:               is_branch = 1'b0;
        endcase

        ctrl_xfer = 1'b0;
        target    = snpc;
        if (is_branch) begin
            ctrl_xfer = taken;
            if (taken) begin
                target = pc + imm_b_x;
            end
        end else begin
            case (next_type)
                TYPE_W'(PC_TYPE_JAL): begin
                    target    = pc + imm_j_x;
                    ctrl_xfer = 1'b1;
                end
                TYPE_W'(PC_TYPE_JALR): begin
                    target    = (rs1 + imm_i_x) & ~XLEN'(1);
                    ctrl_xfer = 1'b1;
                end
                TYPE_W'(PC_TYPE_HALT): target = pc;
                TYPE_W'(PC_TYPE_TRAP),
                TYPE_W'(PC_TYPE_MRET): target = rs1;
                default:               target = snpc;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_25030077_pc_gen.sv
// Next-PC generator: fetch/exec handshake FSM, PC/dnpc registers, retire counter.
// Define YSYX_PC_MISALIGN_EN to trap misaligned jump/branch targets to io_trap_vec.
module ysyx_25030077_pc_gen
    import ysyx_25030077_pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              TYPE_W   = 4,
    parameter int              CNT_W    = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              io_fetch_valid,
    input  logic              io_fetch_ready,
    output logic [XLEN-1:0]   io_fetch_pc,
    input  logic              io_exec_valid,
    output logic              io_exec_ready,
    input  logic [XLEN-1:0]   io_rs1_data,
    input  logic [XLEN-1:0]   io_rs2_data,
    input  logic [31:0]       io_instruction,
    input  logic [TYPE_W-1:0] io_pc_next_type,
    input  logic [XLEN-1:0]   io_trap_vec,
    output logic [XLEN-1:0]   io_dnpc,
    output logic              io_retire,
    output logic [CNT_W-1:0]  io_retire_cnt,
    output logic              io_misalign,
    output logic              io_halted,
    output logic              io_unknown_instr
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] dnpc_q, dnpc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            exec_ready_q, exec_ready_d;
    logic            halted_q, halted_d;
    logic            retire_q, retire_d;
    logic            misalign_q, misalign_d;
    logic            unknown_q, unknown_d;
    logic [XLEN-1:0] target;
    logic            ctrl_xfer;

    ysyx_25030077_pc_target #(
        .XLEN   (XLEN),
        .TYPE_W (TYPE_W)
    ) u_target (
        .pc        (pc_q),
        .rs1       (io_rs1_data),
        .rs2       (io_rs2_data),
        .instr     (io_instruction),
        .next_type (io_pc_next_type),
        .target    (target),
        .ctrl_xfer (ctrl_xfer)
    );

`ifndef YSYX_PC_MISALIGN_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^{io_trap_vec, ctrl_xfer};
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dnpc_d     = dnpc_q;
        cnt_d      = cnt_q;
        retire_d   = 1'b0;
        misalign_d = 1'b0;
        unknown_d  = unknown_q;
        case (state_q)
            S_FETCH: if (io_fetch_ready) state_d = S_EXEC;
            S_EXEC: begin
                if (io_exec_valid) begin
                    if (io_pc_next_type == TYPE_W'(PC_TYPE_UNKNOWN)) begin
                        unknown_d = 1'b1;
                        state_d   = S_HALT;
`ifdef YSYX_PC_MISALIGN_EN
                    end else if (ctrl_xfer && (target[1:0] != 2'b00)) begin
                        pc_d       = io_trap_vec;
                        misalign_d = 1'b1;
                        state_d    = S_FETCH;
`endif
                    end else begin
                        pc_d     = target;
                        dnpc_d   = target;
                        cnt_d    = cnt_q + CNT_W'(1);
                        retire_d = 1'b1;
                        state_d  = (io_pc_next_type == TYPE_W'(PC_TYPE_HALT)) ? S_HALT : S_FETCH;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
        // Handshake/status outputs are registered copies of the next state.
        fetch_valid_d = (state_d == S_FETCH);
        exec_ready_d  = (state_d == S_EXEC);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            dnpc_q        <= RESET_PC;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b1;
            exec_ready_q  <= 1'b0;
            halted_q      <= 1'b0;
            retire_q      <= 1'b0;
            misalign_q    <= 1'b0;
            unknown_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            dnpc_q        <= dnpc_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_valid_d;
            exec_ready_q  <= exec_ready_d;
            halted_q      <= halted_d;
            retire_q      <= retire_d;
            misalign_q    <= misalign_d;
            unknown_q     <= unknown_d;
        end
    end

    assign io_fetch_valid   = fetch_valid_q;
    assign io_fetch_pc      = pc_q;
    assign io_exec_ready    = exec_ready_q;
    assign io_dnpc          = dnpc_q;
    assign io_retire        = retire_q;
    assign io_retire_cnt    = cnt_q;
    assign io_misalign      = misalign_q;
    assign io_halted        = halted_q;
    assign io_unknown_instr = unknown_q;

endmodule

// File: tb/tb_ysyx_25030077_pc_gen.sv
// Randomised scoreboard bench for ysyx_25030077_pc_gen with an instruction-level reference model.
module tb_ysyx_25030077_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_fetch_valid;
    logic        io_fetch_ready;
    logic [31:0] io_fetch_pc;
    logic        io_exec_valid;
    logic        io_exec_ready;
    logic [31:0] io_rs1_data;
    logic [31:0] io_rs2_data;
    logic [31:0] io_instruction;
    logic [3:0]  io_pc_next_type;
    logic [31:0] io_trap_vec;
    logic [31:0] io_dnpc;
    logic        io_retire;
    logic [31:0] io_retire_cnt;
    logic        io_misalign;
    logic        io_halted;
    logic        io_unknown_instr;

    always #5 clock = ~clock;

    ysyx_25030077_pc_gen #(
        .XLEN     (32),
        .TYPE_W   (4),
        .CNT_W    (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_fetch_valid   (io_fetch_valid),
        .io_fetch_ready   (io_fetch_ready),
        .io_fetch_pc      (io_fetch_pc),
        .io_exec_valid    (io_exec_valid),
        .io_exec_ready    (io_exec_ready),
        .io_rs1_data      (io_rs1_data),
        .io_rs2_data      (io_rs2_data),
        .io_instruction   (io_instruction),
        .io_pc_next_type  (io_pc_next_type),
        .io_trap_vec      (io_trap_vec),
        .io_dnpc          (io_dnpc),
        .io_retire        (io_retire),
        .io_retire_cnt    (io_retire_cnt),
        .io_misalign      (io_misalign),
        .io_halted        (io_halted),
        .io_unknown_instr (io_unknown_instr)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] q_fetch[$];
    logic [63:0] q_ret[$];
    logic [31:0] q_mis[$];

    // Reference architectural state
    logic [31:0] mpc, mdnpc, mcnt;
    bit          mhalt, munk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Architectural next-PC rule for one executed instruction.
    function automatic logic [31:0] model_next(input int ty, input logic [31:0] pc,
                                               input logic [31:0] rs1, input logic [31:0] rs2,
                                               input logic [31:0] instr, output bit xfer);
        int  bimm, jimm, iimm;
        bit  tk;
        bimm = $signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        jimm = $signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        iimm = $signed(instr[31:20]);
        xfer = 0;
        case (ty)
            1: begin xfer = 1; return pc + jimm; end
            2: begin xfer = 1; return (rs1 + iimm) & 32'hFFFF_FFFE; end
            4: return pc;
            5, 6, 7, 8, 9, 10: begin
                case (ty)
                    6: tk = (rs1 == rs2);
                    5: tk = (rs1 != rs2);
                    7: tk = ($signed(rs1) >= $signed(rs2));
                    8: tk = (rs1 >= rs2);
                    9: tk = ($signed(rs1) < $signed(rs2));
                    default: tk = (rs1 < rs2);
                endcase
                xfer = tk;
                return tk ? pc + bimm : pc + 32'd4;
            end
            11, 12: return rs1;
            default: return pc + 32'd4;
        endcase
    endfunction

    // Monitor: pops expected responses whenever the DUT presents them.
    always @(negedge clock) begin
        logic [31:0] ef;
        logic [63:0] er;
        if (reset === 1'b0) begin
            if (io_fetch_valid && io_fetch_ready) begin
                checks++;
                if (q_fetch.size() == 0) begin
                    errors++;
                    $display("FAIL fetch_extra: request at 0x%08h, none expected", io_fetch_pc);
                end else begin
                    ef = q_fetch.pop_front();
                    if (io_fetch_pc !== ef) begin
                        errors++;
                        $display("FAIL fetch_pc: got 0x%08h expected 0x%08h", io_fetch_pc, ef);
                    end
                end
            end
            if (io_retire) begin
                checks++;
                if (q_ret.size() == 0) begin
                    errors++;
                    $display("FAIL retire_extra: retire with dnpc 0x%08h cnt %0d, none expected", io_dnpc, io_retire_cnt);
                end else begin
                    er = q_ret.pop_front();
                    if ({io_dnpc, io_retire_cnt} !== er) begin
                        errors++;
                        $display("FAIL retire: got dnpc 0x%08h cnt %0d expected dnpc 0x%08h cnt %0d",
                                 io_dnpc, io_retire_cnt, er[63:32], er[31:0]);
                    end
                end
            end
            if (io_misalign) begin
                checks++;
                if (q_mis.size() == 0) begin
                    errors++;
                    $display("FAIL misalign_extra: misalign pulse, none expected");
                end else begin
                    ef = q_mis.pop_front();
                    if (io_fetch_pc !== ef) begin
                        errors++;
                        $display("FAIL misalign_pc: got 0x%08h expected 0x%08h", io_fetch_pc, ef);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset          = 1'b1;
        io_fetch_ready = 1'b0;
        io_exec_valid  = 1'b0;
        step();
        step();
        reset = 1'b0;
        mpc = RESET_PC; mdnpc = RESET_PC; mcnt = 0; mhalt = 0; munk = 0;
        check("rst_queues_drained", 64'(q_fetch.size() + q_ret.size() + q_mis.size()), 64'd0);
        q_fetch.delete(); q_ret.delete(); q_mis.delete();
        check("rst_fetch_valid", 64'(io_fetch_valid), 64'd1);
        check("rst_fetch_pc", 64'(io_fetch_pc), 64'(RESET_PC));
        check("rst_dnpc", 64'(io_dnpc), 64'(RESET_PC));
        check("rst_flags", 64'({io_exec_ready, io_retire, io_misalign, io_halted, io_unknown_instr}), 64'd0);
        check("rst_cnt", 64'(io_retire_cnt), 64'd0);
    endtask

    // One fetch + execute transaction with random stalls and ignored noise on the EXU side.
    task automatic txn(input int ty, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] instr, input logic [31:0] tv, input int stall);
        logic [31:0] t;
        bit          xfer;
        io_fetch_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            io_exec_valid   = 1'($urandom_range(0, 1));
            io_pc_next_type = 4'($urandom_range(3, 4));
            io_rs1_data     = $urandom;
            step();
            check("stall_valid", 64'(io_fetch_valid), 64'd1);
            check("stall_pc", 64'(io_fetch_pc), 64'(mpc));
            check("stall_cnt", 64'(io_retire_cnt), 64'(mcnt));
        end
        io_exec_valid = 1'b0;
        q_fetch.push_back(mpc);
        io_fetch_ready = 1'b1;
        step();
        io_fetch_ready = 1'b0;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            step();
            check("exec_wait_hs", 64'({io_exec_ready, io_fetch_valid}), 64'b10);
        end
        io_rs1_data = rs1; io_rs2_data = rs2; io_instruction = instr;
        io_pc_next_type = 4'(ty); io_trap_vec = tv;
        io_exec_valid = 1'b1;
        t = model_next(ty, mpc, rs1, rs2, instr, xfer);
        if (ty == 3) begin
            munk = 1; mhalt = 1;
`ifdef YSYX_PC_MISALIGN_EN
        end else if (xfer && t[1:0] != 2'b00) begin
            mpc = tv;
            q_mis.push_back(tv);
`endif
        end else begin
            mpc = t; mdnpc = t; mcnt = mcnt + 1;
            q_ret.push_back({mdnpc, mcnt});
            if (ty == 4) mhalt = 1;
        end
        step();
        io_exec_valid = 1'b0;
        check("post_pc", 64'(io_fetch_pc), 64'(mpc));
        check("post_dnpc_cnt", {io_dnpc, io_retire_cnt}, {mdnpc, mcnt});
        check("post_status", 64'({io_halted, io_unknown_instr, io_fetch_valid}),
              64'({mhalt, munk, !mhalt}));
    endtask

    task automatic check_halt_hold();
        io_fetch_ready = 1'b1;
        io_exec_valid  = 1'b1;
        io_pc_next_type = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("halt_hold", 64'({io_halted, io_fetch_valid, io_exec_ready}), 64'b100);
            check("halt_cnt", 64'(io_retire_cnt), 64'(mcnt));
        end
        io_fetch_ready = 1'b0;
        io_exec_valid  = 1'b0;
    endtask

    initial begin
        int ty;
        logic [31:0] a, b;
        io_rs1_data = '0; io_rs2_data = '0; io_instruction = '0;
        io_pc_next_type = '0; io_trap_vec = '0;
        do_reset();

        txn(0, 0, 0, 32'h0000_0013, 0, 0);
        txn(0, 0, 0, 32'h0000_0013, 0, 5);
        txn(0, 0, 0, 32'h0000_0013, 0, 1);
        txn(0, 0, 0, 32'h0000_0013, 0, 0);
        txn(6, 5, 5, 32'hFE00_0EE3, 0, 2);
        txn(5, 5, 5, 32'hFE00_0EE3, 0, 0);
        txn(9, 32'hFFFF_FFFF, 1, 32'h0000_0863, 0, 1);
        txn(10, 32'hFFFF_FFFF, 1, 32'h0000_0863, 0, 0);
        txn(7, 9, 9, 32'h0000_0863, 0, 0);
        txn(8, 9, 9, 32'h0000_0863, 0, 0);
        txn(9, 9, 9, 32'h0000_0863, 0, 0);
        txn(10, 9, 9, 32'h0000_0863, 0, 0);
        txn(2, 32'hFFFF_FFFC, 0, 32'h0000_0067, 0, 0);
        txn(0, 0, 0, 32'h0000_0013, 0, 0);
        txn(11, 32'h8000_0200, 0, 0, 0, 0);
        txn(1, 0, 0, 32'h0100_006F, 0, 0);

        for (int n = 0; n < 150; n++) begin
            ty = int'($urandom_range(0, 15));
            if (ty == 3 || ty == 4) ty = 0;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            txn(ty, a, b, $urandom, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
        end

        txn(4, 0, 0, 0, 0, 1);
        check_halt_hold();
        do_reset();
        txn(0, 0, 0, 0, 0, 0);
        txn(3, 0, 0, 0, 0, 0);
        check_halt_hold();
        do_reset();

        // Reset asserted in the same cycle as a pending EXU result.
        q_fetch.push_back(mpc);
        io_fetch_ready = 1'b1;
        step();
        io_fetch_ready = 1'b0;
        io_pc_next_type = 4'd1; io_instruction = 32'h0100_006F;
        io_exec_valid = 1'b1;
        do_reset();
        txn(0, 0, 0, 0, 0, 0);

`ifdef YSYX_PC_MISALIGN_EN
        txn(2, 32'h8000_0002, 0, 32'h0000_0067, 32'h8000_0100, 0);
        check("mis_no_retire", 64'(io_retire_cnt), 64'd1);
        txn(0, 0, 0, 0, 0, 0);
`endif

        step();
        step();
        check("end_queues_drained", 64'(q_fetch.size() + q_ret.size() + q_mis.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
